// File: rtl/seg_mux_display_if.sv
// ============================================================================
// Module      : seg_mux_display_if
// Description : Bundle between the stopwatch counter (master) and the
//               multiplexed seven-segment driver (slave).
//               master : drives digits, dp_in, blank; observes an, sseg, frame
//               slave  : consumes digits, dp_in, blank; drives an, sseg, frame
//               digits : packed BCD, digit3 in [15:12] .. digit0 in [3:0]
//               dp_in  : decimal-point request per digit, active-high
//               blank  : forces every anode off while high
//               an     : anode enables, active-low, bit i = digit i
//               sseg   : segments, active-low, {dp,g,f,e,d,c,b,a}
//               frame  : one-clock pulse when a new snapshot is taken
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_mux_display_if;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        blank;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame;

    modport master (
        output digits,
        output dp_in,
        output blank,
        input  an,
        input  sseg,
        input  frame
    );

    modport slave (
        input  digits,
        input  dp_in,
        input  blank,
        output an,
        output sseg,
        output frame
    );
endinterface

`default_nettype wire

// File: rtl/seg_mux_display.sv
// ============================================================================
// Module      : seg_mux_display
// Description : Time-multiplexes four packed-BCD digits onto a common-anode
//               seven-segment display. The input is snapshotted once per
//               scan so a digit change never tears across one frame.
//               Ports:
//                 clk   - system clock
//                 reset - asynchronous, active-low reset
//                 disp  - seg_mux_display_if.slave (digits, dp_in, blank in;
//                         an, sseg, frame out)
//               Parameters:
//                 REFRESH_POWER - refresh counter width (>= 4); one digit
//                                 slot is 2^(REFRESH_POWER-2) clocks
//               Optional build macro:
//                 LEADING_ZERO_BLANK_EN - suppress leading zeros on digits
//                                         3..1 (digit0 always shown)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_mux_display #(
    parameter int REFRESH_POWER = 18
) (
    input  wire logic          clk,
    input  wire logic          reset,
    seg_mux_display_if.slave   disp
);

    localparam logic [REFRESH_POWER-1:0] c_q_max = '1;

    logic [REFRESH_POWER-1:0] r_q;
    logic [15:0]              r_snap_digits;
    logic [3:0]               r_snap_dp;
    logic [3:0]               r_an;
    logic [7:0]               r_sseg;
    logic                     r_frame;

    logic [1:0]               w_sel;
    logic [3:0]               w_nibble;
    logic [6:0]               w_seg;
    logic                     w_lead_blank;
    logic                     w_capture;

    // The two MSBs of the free-running counter pick the active digit.
    assign w_sel     = r_q[REFRESH_POWER-1 -: 2];
    assign w_nibble  = r_snap_digits[w_sel*4 +: 4];
    // Capture on the last clock of a scan so the new value enters at slot 0.
    assign w_capture = (r_q == c_q_max);

    // Active-low hex decode; anything outside 0-9 is shown as a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blanked when it and every more-significant digit are zero.
    // Invalid nibbles are nonzero, so they stop the suppression.
    always_comb begin
        w_lead_blank = 1'b0;
        case (w_sel)
            2'd3:    w_lead_blank = (r_snap_digits[15:12] == 4'h0);
            2'd2:    w_lead_blank = (r_snap_digits[15:8]  == 8'h00);
            2'd1:    w_lead_blank = (r_snap_digits[15:4]  == 12'h000);
            default: w_lead_blank = 1'b0;
        endcase
    end
`else
    assign w_lead_blank = 1'b0;
`endif

    assign w_seg = w_lead_blank ? 7'h7F : bcd_to_seg(w_nibble);

    // Refresh counter and snapshot registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q           <= '0;
            r_snap_digits <= 16'h0000;
            r_snap_dp     <= 4'h0;
            r_frame       <= 1'b0;
        end else begin
            r_q     <= r_q + 1'b1;
            r_frame <= w_capture;
            if (w_capture) begin
                r_snap_digits <= disp.digits;
                r_snap_dp     <= disp.dp_in;
            end
        end
    end

    // Output stage: one clock behind the select so the pins are glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an   <= 4'hF;
            r_sseg <= 8'hFF;
        end else if (disp.blank) begin
            r_an   <= 4'hF;
            r_sseg <= 8'hFF;
        end else begin
            r_an   <= ~(4'b0001 << w_sel);
            r_sseg <= {~r_snap_dp[w_sel], w_seg};
        end
    end

    assign disp.an    = r_an;
    assign disp.sseg  = r_sseg;
    assign disp.frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_seg_mux_display.sv
// ============================================================================
// Module      : tb_seg_mux_display
// Description : Self-checking bench for seg_mux_display with
//               REFRESH_POWER=4 (4-clock slots, 16-clock scan). A reference
//               model tracks the scan position, the snapshot and the
//               expected pins arithmetically; directed scenarios are
//               followed by randomized digits, decimal points and blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_mux_display;

    localparam int RP   = 4;
    localparam int SCAN = 16;
    localparam int SLOT = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg_mux_display_if disp();

    seg_mux_display #(.REFRESH_POWER(RP)) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_cnt;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    logic [6:0]  seg_tab [16];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at time %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_sseg(input int slot, input logic [15:0] snap,
                                              input logic [3:0] dp);
        int         nib;
        logic [6:0] s;
        nib = int'((snap >> (4 * slot)) & 16'hF);
        s   = seg_tab[nib];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot != 0 && (snap >> (4 * slot)) == 16'h0) s = 7'h7F;
`endif
        return {~dp[slot], s};
    endfunction

    // Called just after a falling edge with inputs already settled.
    // Predicts the pins after the next rising edge, then checks them.
    task automatic step();
        int         slot;
        logic [3:0] e_an;
        logic [7:0] e_ss;
        logic       e_fr;
        slot = m_cnt / SLOT;
        if (disp.blank) begin
            e_an = 4'hF;
            e_ss = 8'hFF;
        end else begin
            e_an = 4'(15 - (1 << slot));
            e_ss = model_sseg(slot, m_snap, m_dp);
        end
        e_fr = (m_cnt == SCAN - 1);
        if (m_cnt == SCAN - 1) begin
            m_snap = disp.digits;
            m_dp   = disp.dp_in;
        end
        m_cnt = (m_cnt + 1) % SCAN;
        @(posedge clk);
        #1;
        chk("an",    16'(disp.an),    16'(e_an));
        chk("sseg",  16'(disp.sseg),  16'(e_ss));
        chk("frame", 16'(disp.frame), 16'(e_fr));
        if (!disp.blank)
            chk("one_anode", 16'($countones(disp.an)), 16'd3);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model reaches a given scan position (bounded).
    task automatic run_to(input int pos);
        for (int i = 0; i < 2 * SCAN && m_cnt != pos; i++) step();
        chk("run_to_pos", 16'(m_cnt), 16'(pos));
    endtask

    // Assert reset between edges, check it acts immediately and holds.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_an",    16'(disp.an),    16'hF);
        chk("rst_sseg",  16'(disp.sseg),  16'hFF);
        chk("rst_frame", 16'(disp.frame), 16'h0);
        m_cnt  = 0;
        m_snap = 16'h0;
        m_dp   = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_an",   16'(disp.an),   16'hF);
            chk("rst_hold_sseg", 16'(disp.sseg), 16'hFF);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        reset       = 1'b0;
        disp.digits = 16'h0;
        disp.dp_in  = 4'h0;
        disp.blank  = 1'b0;
        @(negedge clk);
        do_reset();

        // First output after release: digit0 of the zero snapshot.
        disp.digits = 16'h1234;
        step();
        chk("first_an",   16'(disp.an),   16'hE);
        chk("first_sseg", 16'(disp.sseg), 16'hC0);
        run(40);

        // Decimal point on digit 2 only.
        disp.digits = 16'h5678;
        disp.dp_in  = 4'b0100;
        run(36);
        disp.dp_in  = 4'h0;

        // Mid-scan change stays invisible until the next capture.
        disp.digits = 16'h1111;
        run(20);
        run_to(6);
        disp.digits = 16'h2222;
        run(32);

        // Invalid nibbles show a dash.
        disp.digits = 16'hA9F0;
        run(36);

        // Leading-zero cases (full decode when the feature is off).
        disp.digits = 16'h0050;
        run(36);
        disp.digits = 16'h0000;
        run(36);

        // Blank burst straddling the capture point.
        disp.digits = 16'h4321;
        run(20);
        run_to(10);
        disp.blank = 1'b1;
        run(10);
        disp.blank = 1'b0;
        run(20);

        // Reset in the middle of a scan.
        run_to(7);
        do_reset();
        run(36);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) disp.digits = 16'($urandom);
            if ($urandom_range(0, 15) == 0) disp.dp_in = 4'($urandom);
            if ($urandom_range(0, 19) == 0) disp.blank = ~disp.blank;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
